lzc_norm_pipe: RTL

LZC_NORM_PIPE -- requirements
Module: lzc_norm_pipe

---
 rtl/lzc_norm_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lzc_norm_pipe.sv
// ============================================================================
// lzc_norm_pipe : two-stage normalizer; shifts out leading zeros, clamped so
//                 the biased exponent never underflows below zero.
// Optional: define LZC_NORM_CHECK_EN for an independent LZC cross-check (out_err).
// Revision: 1.0
// ============================================================================
`default_nettype none

module lzc_norm_pipe #(
  parameter int WIDTH = 16,
  parameter int EXP_W = 8,
  parameter int COUNT = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [COUNT-1:0] in_z,
  input  logic             in_nv,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [COUNT-1:0] out_shift,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_uflow,
  output logic             out_err
);

  localparam int CMPW = (COUNT > EXP_W) ? COUNT : EXP_W;
  localparam logic [CMPW-1:0] C_MAX_SH = CMPW'(WIDTH - 1);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [COUNT-1:0] s1_sh_q,    s1_sh_d;
  logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
  logic             s1_zero_q,  s1_zero_d;
  logic             s1_uflow_q, s1_uflow_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [COUNT-1:0] out_shift_q, out_shift_d;
  logic [EXP_W-1:0] out_exp_q,   out_exp_d;
  logic             out_zero_q,  out_zero_d;
  logic             out_uflow_q, out_uflow_d;

  logic            s2_adv;
  logic            s1_adv;
  logic [CMPW-1:0] z_ext;
  logic [CMPW-1:0] e_ext;
  logic [CMPW-1:0] sh_ext;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // S1: clamp the shift to the exponent so a tiny exponent yields a denormal
  always_comb begin
    z_ext  = CMPW'(in_z);
    e_ext  = CMPW'(in_exp);
    sh_ext = (z_ext < e_ext) ? z_ext : e_ext;
    if (sh_ext > C_MAX_SH) sh_ext = C_MAX_SH;
    if (!in_nv) sh_ext = '0;

    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sh_d    = s1_sh_q;
    s1_exp_d   = s1_exp_q;
    s1_zero_d  = s1_zero_q;
    s1_uflow_d = s1_uflow_q;
    if (s1_adv && in_valid) begin
      s1_data_d  = in_nv ? in_data : '0;
      s1_sh_d    = COUNT'(sh_ext);
      s1_exp_d   = in_nv ? (in_exp - EXP_W'(sh_ext)) : '0;
      s1_zero_d  = !in_nv;
      s1_uflow_d = in_nv && (z_ext > e_ext);
    end
  end

  // S2: barrel shift and register the result
  always_comb begin
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    out_data_d  = out_data_q;
    out_shift_d = out_shift_q;
    out_exp_d   = out_exp_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    if (s2_adv && s1_valid_q) begin
      out_data_d  = s1_data_q << s1_sh_q;
      out_shift_d = s1_sh_q;
      out_exp_d   = s1_exp_q;
      out_zero_d  = s1_zero_q;
      out_uflow_d = s1_uflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sh_q     <= '0;
      s1_exp_q    <= '0;
      s1_zero_q   <= 1'b0;
      s1_uflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sh_q     <= s1_sh_d;
      s1_exp_q    <= s1_exp_d;
      s1_zero_q   <= s1_zero_d;
      s1_uflow_q  <= s1_uflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_shift_q <= out_shift_d;
      out_exp_q   <= out_exp_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_shift = out_shift_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

`ifdef LZC_NORM_CHECK_EN
  logic [COUNT-1:0] ref_z;
  logic             ref_nv;
  logic             s1_err_q, s1_err_d;
  logic             out_err_q, out_err_d;

  // Ascending scan: the last hit is the most significant set bit
  always_comb begin
    ref_z  = '0;
    ref_nv = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) begin
        ref_z  = COUNT'(WIDTH - 1 - i);
        ref_nv = 1'b1;
      end
    end
    s1_err_d = s1_err_q;
    if (s1_adv && in_valid)
      s1_err_d = (in_nv != ref_nv) || (ref_nv && (in_z != ref_z));
    out_err_d = out_err_q || (s2_adv && s1_valid_q && s1_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err_q  <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      s1_err_q  <= s1_err_d;
      out_err_q <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

`default_nettype wire
